// File: rtl/system_cpu_dct_pkg.sv
// -----------------------------------------------------------------------------
// system_cpu_dct_pkg
// Shared definitions for the CPU direct-conditional (DCT) trace controller:
// branch-outcome codes, accumulator/frame widths, the frame-slot FSM state
// type and a helper that classifies an incoming outcome code.
// -----------------------------------------------------------------------------
package system_cpu_dct_pkg;

   localparam logic [1:0] DCT_CODE_TAKEN  = 2'b01;
   localparam logic [1:0] DCT_CODE_NTAKEN = 2'b10;

   localparam int DCT_BUF_W = 30;                    // 15 entries x 2 bits
   localparam int DCT_CNT_W = 4;
   localparam int FRAME_W   = DCT_CNT_W + DCT_BUF_W; // {count, buffer}

   typedef enum logic {
      SLOT_IDLE = 1'b0,
      SLOT_PEND = 1'b1
   } slot_state_t;

   // True for the two codes that carry a branch outcome; 00/11 are ignored.
   function automatic logic is_dct_code(input logic [1:0] code);
      return (code == DCT_CODE_TAKEN) || (code == DCT_CODE_NTAKEN);
   endfunction

endpackage

// File: rtl/system_cpu_dct_frame_slot.sv
// -----------------------------------------------------------------------------
// system_cpu_dct_frame_slot
// Single-entry valid/ready holding register for completed trace frames.
// A frame loaded while the slot is free is presented on o_data/o_valid and
// held stable until the downstream writer accepts it.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset
//   i_load   in   capture i_data this edge (only honoured while o_free)
//   i_data   in   frame to capture
//   i_ready  in   downstream accepts the presented frame
//   o_valid  out  slot holds a frame
//   o_data   out  held frame
//   o_free   out  slot can take a new frame this cycle (empty or draining)
// -----------------------------------------------------------------------------
module system_cpu_dct_frame_slot
   import system_cpu_dct_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               i_load,
   input  logic [FRAME_W-1:0] i_data,
   input  logic               i_ready,
   output logic               o_valid,
   output logic [FRAME_W-1:0] o_data,
   output logic               o_free
);

   slot_state_t        r_state;
   slot_state_t        w_state_nxt;
   logic [FRAME_W-1:0] r_data;
   logic               w_free;

   // State register and frame holding register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values of its inputs regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= SLOT_IDLE;
         // NOTE: the data register is cleared on reset because frame_data is
         // an observable output that must read zero; pure storage with no
         // visible reset value would be left unreset.
         r_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (i_load && w_free) begin
            r_data <= i_data;
         end
      end
   end

   // Next-state logic.
   // NOTE: the default assignment first keeps every path assigned, so no
   // latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         SLOT_IDLE: if (i_load) w_state_nxt = SLOT_PEND;
         SLOT_PEND: if (i_ready) w_state_nxt = i_load ? SLOT_PEND : SLOT_IDLE;
         default:   w_state_nxt = SLOT_IDLE;
      endcase
   end

   // Outputs. A handshake completing this cycle frees the slot for a
   // back-to-back load on the same edge.
   always_comb begin
      o_valid = (r_state == SLOT_PEND);
      w_free  = (r_state == SLOT_IDLE) || ((r_state == SLOT_PEND) && i_ready);
      o_free  = w_free;
      o_data  = r_data;
   end

endmodule

// File: rtl/system_cpu_dct_trace_ctrl.sv
// -----------------------------------------------------------------------------
// system_cpu_dct_trace_ctrl
// Packs 2-bit direct-conditional branch outcomes into trace frames of up to
// DCT_DEPTH entries. A frame is emitted when the accumulator is full, when a
// flush is pending, or when tracing is switched off, and is handed to a
// one-entry valid/ready slot. The CPU cannot stall, so entries arriving while
// the accumulator is full and the slot is busy are dropped and flagged.
//
// Optional feature macro: SYSTEM_CPU_DCT_OVF_CNT_EN adds ovf_count[7:0], a
// saturating count of dropped entries.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   synchronous active-high reset
//   trace_en      in   trace capture enable
//   dct_in_valid  in   branch outcome present this cycle
//   dct_in_code   in   01 taken, 10 not-taken, 00/11 ignored
//   flush_req     in   pulse: emit the partial frame
//   frame_ready   in   downstream writer accepts the frame
//   frame_valid   out  frame slot holds a frame
//   frame_data    out  {count[3:0], buffer[29:0]}
//   dct_buffer    out  live accumulator contents
//   dct_count     out  live accumulator entry count
//   flush_ack     out  one-cycle pulse when a flush is serviced
//   overflow      out  sticky: an entry was dropped
//   ovf_count     out  dropped-entry count, saturating (macro only)
// -----------------------------------------------------------------------------
module system_cpu_dct_trace_ctrl
   import system_cpu_dct_pkg::*;
#(
   parameter int DCT_DEPTH = 15   // legal 1..15
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 trace_en,
   input  logic                 dct_in_valid,
   input  logic [1:0]           dct_in_code,
   input  logic                 flush_req,
   input  logic                 frame_ready,
   output logic                 frame_valid,
   output logic [FRAME_W-1:0]   frame_data,
   output logic [DCT_BUF_W-1:0] dct_buffer,
   output logic [DCT_CNT_W-1:0] dct_count,
   output logic                 flush_ack,
   output logic                 overflow
`ifdef SYSTEM_CPU_DCT_OVF_CNT_EN
   ,
   output logic [7:0]           ovf_count
`endif
);

   localparam logic [DCT_CNT_W-1:0] DEPTH_CNT = DCT_CNT_W'(DCT_DEPTH);

   logic [DCT_BUF_W-1:0] r_buffer;
   logic [DCT_CNT_W-1:0] r_count;
   logic                 r_flush_pending;
   logic                 r_trace_en_d;
   logic                 r_flush_ack;
   logic                 r_overflow;

   logic w_code_ok, w_full, w_nonempty, w_te_fall;
   logic w_emit_req, w_emit, w_flush_srv, w_drop, w_slot_free;

   assign w_code_ok   = trace_en && dct_in_valid && is_dct_code(dct_in_code);
   assign w_full      = (r_count == DEPTH_CNT);
   assign w_nonempty  = (r_count != '0);
   assign w_te_fall   = r_trace_en_d && !trace_en;
   assign w_emit_req  = w_full || (w_nonempty && (r_flush_pending || w_te_fall));
   assign w_emit      = w_emit_req && w_slot_free;
   // An empty flush is acknowledged without a frame; a non-empty one is
   // acknowledged on the same edge its frame is emitted.
   assign w_flush_srv = r_flush_pending && w_slot_free;
   assign w_drop      = w_code_ok && w_full && !w_emit;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_buffer        <= '0;
         r_count         <= '0;
         r_flush_pending <= 1'b0;
         r_trace_en_d    <= 1'b0;
         r_flush_ack     <= 1'b0;
         r_overflow      <= 1'b0;
      end else begin
         r_trace_en_d <= trace_en;
         r_flush_ack  <= w_flush_srv;
         // A request arriving while one is pending merges into it.
         r_flush_pending <= r_flush_pending ? !w_flush_srv : flush_req;

         if (w_emit) begin
            // The frame takes the old contents; a same-cycle entry starts
            // the fresh accumulator.
            if (w_code_ok) begin
               r_buffer <= {{(DCT_BUF_W-2){1'b0}}, dct_in_code};
               r_count  <= DCT_CNT_W'(1);
            end else begin
               r_buffer <= '0;
               r_count  <= '0;
            end
         end else if (w_code_ok && !w_full) begin
            r_buffer <= {r_buffer[DCT_BUF_W-3:0], dct_in_code};
            r_count  <= r_count + DCT_CNT_W'(1);
         end

         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

`ifdef SYSTEM_CPU_DCT_OVF_CNT_EN
   logic [7:0] r_ovf_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ovf_count <= '0;
      end else if (w_drop && (r_ovf_count != 8'hFF)) begin
         r_ovf_count <= r_ovf_count + 8'd1;
      end
   end

   assign ovf_count = r_ovf_count;
`endif

   system_cpu_dct_frame_slot u_slot (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_emit),
      .i_data  ({r_count, r_buffer}),
      .i_ready (frame_ready),
      .o_valid (frame_valid),
      .o_data  (frame_data),
      .o_free  (w_slot_free)
   );

   assign dct_buffer = r_buffer;
   assign dct_count  = r_count;
   assign flush_ack  = r_flush_ack;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_system_cpu_dct_trace_ctrl.sv
// -----------------------------------------------------------------------------
// tb_system_cpu_dct_trace_ctrl
// Directed stimulus with hand-computed frames pushed into a scoreboard queue;
// a negedge monitor pops and compares on every frame handshake. Register
// state (counts, flags, held frame) is checked directly from the stimulus.
// -----------------------------------------------------------------------------
module tb_system_cpu_dct_trace_ctrl;
   import system_cpu_dct_pkg::*;

   logic                 clk          = 1'b0;
   logic                 reset        = 1'b1;
   logic                 trace_en     = 1'b0;
   logic                 dct_in_valid = 1'b0;
   logic [1:0]           dct_in_code  = 2'b00;
   logic                 flush_req    = 1'b0;
   logic                 frame_ready  = 1'b1;
   logic                 frame_valid;
   logic [FRAME_W-1:0]   frame_data;
   logic [DCT_BUF_W-1:0] dct_buffer;
   logic [DCT_CNT_W-1:0] dct_count;
   logic                 flush_ack;
   logic                 overflow;
`ifdef SYSTEM_CPU_DCT_OVF_CNT_EN
   logic [7:0]           ovf_count;
`endif

   int n_cmp   = 0;
   int n_err   = 0;
   int ack_cnt = 0;
   int ack_base;
   logic [FRAME_W-1:0] sb_q[$];
   logic [FRAME_W-1:0] mon_exp;

   localparam logic [FRAME_W-1:0] FR_TAKEN15  = {4'hF, 30'h15555555};
   localparam logic [FRAME_W-1:0] FR_NTAKEN15 = {4'hF, 30'h2AAAAAAA};

   always #5 clk = ~clk;

   system_cpu_dct_trace_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .trace_en     (trace_en),
      .dct_in_valid (dct_in_valid),
      .dct_in_code  (dct_in_code),
      .flush_req    (flush_req),
      .frame_ready  (frame_ready),
      .frame_valid  (frame_valid),
      .frame_data   (frame_data),
      .dct_buffer   (dct_buffer),
      .dct_count    (dct_count),
      .flush_ack    (flush_ack),
      .overflow     (overflow)
`ifdef SYSTEM_CPU_DCT_OVF_CNT_EN
      ,
      .ovf_count    (ovf_count)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_frame_valid"}, 64'(frame_valid), 64'd0);
      check({tag, "_frame_data"},  64'(frame_data),  64'd0);
      check({tag, "_dct_buffer"},  64'(dct_buffer),  64'd0);
      check({tag, "_dct_count"},   64'(dct_count),   64'd0);
      check({tag, "_flush_ack"},   64'(flush_ack),   64'd0);
      check({tag, "_overflow"},    64'(overflow),    64'd0);
`ifdef SYSTEM_CPU_DCT_OVF_CNT_EN
      check({tag, "_ovf_count"},   64'(ovf_count),   64'd0);
`endif
   endtask

   // Scoreboard monitor: every accepted frame must match the queue head.
   always @(negedge clk) begin
      if (flush_ack) ack_cnt++;
      if (!reset && frame_valid && frame_ready) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_frame: got %0h expected none", frame_data);
         end else begin
            mon_exp = sb_q.pop_front();
            check("frame_handshake", 64'(frame_data), 64'(mon_exp));
         end
      end
   end

   initial begin
      // ---- reset state ----
      tick();
      tick();
      check_all_zero("reset");
      reset = 1'b0;

      // ---- ignored inputs: codes 00/11, and a valid code with trace off ----
      dct_in_valid = 1'b1;
      dct_in_code  = 2'b01;
      tick();
      trace_en    = 1'b1;
      dct_in_code = 2'b00;
      tick();
      dct_in_code = 2'b11;
      tick();
      dct_in_valid = 1'b0;
      check("ignored_count",  64'(dct_count),  64'd0);
      check("ignored_buffer", 64'(dct_buffer), 64'd0);

      // ---- full frame: 15 taken entries ----
      sb_q.push_back(FR_TAKEN15);
      dct_in_valid = 1'b1;
      dct_in_code  = DCT_CODE_TAKEN;
      repeat (15) tick();
      dct_in_valid = 1'b0;
      check("full_count15",   64'(dct_count),   64'd15);
      check("full_no_valid",  64'(frame_valid), 64'd0);
      tick();
      check("full_valid",     64'(frame_valid), 64'd1);
      check("full_data",      64'(frame_data),  64'(FR_TAKEN15));
      check("full_count_clr", 64'(dct_count),   64'd0);
      tick();
      check("full_drained",   64'(frame_valid), 64'd0);

      // ---- partial flush: 01, 10, 01 ----
      ack_base = ack_cnt;
      sb_q.push_back({4'h3, 30'h00000019});
      dct_in_valid = 1'b1;
      dct_in_code = 2'b01; tick();
      dct_in_code = 2'b10; tick();
      dct_in_code = 2'b01; tick();
      dct_in_valid = 1'b0;
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      check("pflush_no_ack_yet", 64'(flush_ack), 64'd0);
      tick();
      check("pflush_ack",   64'(flush_ack),   64'd1);
      check("pflush_valid", 64'(frame_valid), 64'd1);
      tick();
      check("pflush_ack_pulse", 64'(flush_ack), 64'd0);
      tick();
      check("pflush_ack_once",  64'(ack_cnt - ack_base), 64'd1);
      check("pflush_count_clr", 64'(dct_count), 64'd0);

      // ---- empty flush, with a second request merging into the first ----
      ack_base = ack_cnt;
      flush_req = 1'b1;
      tick();
      tick();
      flush_req = 1'b0;
      check("eflush_ack",      64'(flush_ack),   64'd1);
      check("eflush_no_frame", 64'(frame_valid), 64'd0);
      tick();
      check("eflush_ack_pulse", 64'(flush_ack), 64'd0);
      tick();
      check("eflush_merged_once", 64'(ack_cnt - ack_base), 64'd1);
      check("eflush_no_frame2",   64'(frame_valid), 64'd0);

      // ---- trace_en falling edge emits a partial frame: 10, 10 ----
      sb_q.push_back({4'h2, 30'h0000000A});
      dct_in_valid = 1'b1;
      dct_in_code  = 2'b10;
      repeat (2) tick();
      dct_in_valid = 1'b0;
      trace_en     = 1'b0;
      tick();
      check("tefall_valid", 64'(frame_valid), 64'd1);
      check("tefall_data",  64'(frame_data),  64'({4'h2, 30'h0000000A}));
      trace_en = 1'b1;
      tick();

      // ---- simultaneous emit and accept ----
      sb_q.push_back(FR_NTAKEN15);
      dct_in_valid = 1'b1;
      dct_in_code  = DCT_CODE_NTAKEN;
      repeat (15) tick();
      dct_in_code = DCT_CODE_TAKEN;
      tick();
      dct_in_valid = 1'b0;
      check("simul_frame",  64'(frame_data), 64'(FR_NTAKEN15));
      check("simul_count",  64'(dct_count),  64'd1);
      check("simul_buffer", 64'(dct_buffer), 64'd1);
      sb_q.push_back({4'h1, 30'h00000001});
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      repeat (3) tick();
      check("simul_flushed", 64'(dct_count), 64'd0);

      // ---- backpressure overflow: 31 entries with frame_ready low ----
      frame_ready  = 1'b0;
      dct_in_valid = 1'b1;
      dct_in_code  = DCT_CODE_TAKEN;
      for (int i = 0; i < 31; i++) begin
         tick();
         if (i == 20) check("bp_hold_mid", 64'(frame_data), 64'(FR_TAKEN15));
         if (i == 29) begin
            check("bp_count30",  64'(dct_count), 64'd15);
            check("bp_no_ovf30", 64'(overflow),  64'd0);
         end
      end
      dct_in_valid = 1'b0;
      check("bp_count",   64'(dct_count),   64'd15);
      check("bp_ovf",     64'(overflow),    64'd1);
      check("bp_valid",   64'(frame_valid), 64'd1);
      check("bp_hold",    64'(frame_data),  64'(FR_TAKEN15));
      check("bp_buffer",  64'(dct_buffer),  64'h15555555);
`ifdef SYSTEM_CPU_DCT_OVF_CNT_EN
      check("bp_ovf_count", 64'(ovf_count), 64'd1);
`endif
      sb_q.push_back(FR_TAKEN15);
      sb_q.push_back(FR_TAKEN15);
      frame_ready = 1'b1;
      repeat (3) tick();
      check("bp_drained",     64'(frame_valid), 64'd0);
      check("bp_count_clr",   64'(dct_count),   64'd0);
      check("bp_ovf_sticky",  64'(overflow),    64'd1);

      // ---- reset while a frame is pending ----
      frame_ready  = 1'b0;
      dct_in_valid = 1'b1;
      dct_in_code  = 2'b01;
      tick();
      dct_in_valid = 1'b0;
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      tick();
      check("rpend_valid", 64'(frame_valid), 64'd1);
      reset = 1'b1;
      tick();
      check_all_zero("rpend");
      reset       = 1'b0;
      frame_ready = 1'b1;
      repeat (2) tick();
      check("rpend_no_frame", 64'(frame_valid), 64'd0);

      // ---- scoreboard must be drained ----
      check("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/system_cpu_dct_trace_ctrl.md
SYSTEM_CPU_DCT_TRACE_CTRL -- requirements
Module: system_cpu_dct_trace_ctrl

Interface
REQ-001 Parameter DCT_DEPTH, default 15, max direct-conditional entries per frame (legal 1..15).
REQ-002 Parameter FRAME_W, default 34, frame width = 4 + 2*15; fixed, not user-overridden.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 trace_en  in  1  trace capture enable.
REQ-006 dct_in_valid  in  1  branch outcome present this cycle; no ready path, because the CPU cannot stall.
REQ-007 dct_in_code  in  2  01 taken, 10 not-taken, 00/11 ignored.
REQ-008 flush_req  in  1  single-cycle pulse; emit partial frame (test-ending flush).
REQ-009 frame_ready  in  1  downstream trace writer accepts frame.
REQ-010 frame_valid  out  1  frame slot holds a frame.
REQ-011 frame_data  out  FRAME_W  {count[3:0], buffer[29:0]}.
REQ-012 dct_buffer  out  30  live accumulator contents.
REQ-013 dct_count  out  4  live accumulator entry count.
REQ-014 flush_ack  out  1  one-cycle pulse when a flush is serviced.
REQ-015 overflow  out  1  sticky flag: an entry was dropped.

Function
REQ-016 Accept: when trace_en=1, dct_in_valid=1 and the code is 01/10, the entry SHALL shift in: buffer <= {buffer[27:0], code}; count <= count+1.
REQ-017 Codes 00/11, and any input while trace_en=0, SHALL be ignored with no state change.
REQ-018 Frame-slot FSM SHALL have two states: IDLE (frame_valid=0) and PEND (frame_valid=1).
REQ-019 Transfer: PEND->IDLE occurs on frame_valid & frame_ready.
REQ-020 The slot is free when state=IDLE or a handshake completes this cycle.
REQ-021 Emit condition (registered state only): count==DEPTH, or flush_pending with count>0, or a trace_en 1->0 edge with count>0.
REQ-022 On emit with slot free: frame_data <= {count, buffer}, frame_valid <= 1, accumulator cleared; the state is PEND next cycle.
REQ-023 Latency: the DEPTH-th entry accepted at edge N gives frame_valid=1 after edge N+1.
REQ-024 Simultaneous emit and accept: the frame captures the old accumulator; the new entry lands in the cleared accumulator (count=1).
REQ-025 Accumulator full and slot busy: an incoming valid entry SHALL be dropped and overflow set; the accumulator stays unchanged.
REQ-026 flush_req SHALL set flush_pending.
REQ-027 Servicing a flush clears flush_pending and pulses flush_ack.
REQ-028 A flush is serviced when the slot is free: with count>0 by emitting; with count=0 immediately, with no frame.
REQ-029 A flush_req arriving while flush_pending=1 SHALL merge (single ack).
REQ-030 frame_data SHALL be stable while frame_valid=1 and frame_ready=0.
REQ-031 overflow SHALL clear only on reset.

Reset
REQ-032 When reset=1 at an edge, all outputs SHALL be 0: frame_valid, frame_data, dct_buffer, dct_count, flush_ack, overflow, ovf_count.
REQ-033 Reset SHALL also clear flush_pending, the trace_en edge register and the FSM state (to IDLE).
REQ-034 Reset mid-frame (PEND) SHALL discard the frame; no handshake is implied.

Configuration
REQ-035 Macro SYSTEM_CPU_DCT_OVF_CNT_EN defined: an output port ovf_count[7:0] SHALL be present.
REQ-036 ovf_count increments per dropped entry and saturates at 255.
REQ-037 Macro SYSTEM_CPU_DCT_OVF_CNT_EN undefined: port and counter absent; overflow flag only.

Structure
REQ-038 Package system_cpu_dct_pkg SHALL hold DCT_CODE_TAKEN=2'b01, DCT_CODE_NTAKEN=2'b10, DCT_BUF_W=30, DCT_CNT_W=4, FRAME_W, and the slot FSM state typedef.
REQ-039 One sub-module: system_cpu_dct_frame_slot, the valid/ready holding register plus its FSM.
REQ-040 The accumulator and flush logic SHALL stay in the top module.

Verification
REQ-041 Full frame: 15 consecutive taken (01) entries -> frame_valid 1 cycle later, frame_data={4'hF, 30'h15555555}, dct_count=0.
REQ-042 Partial flush: 3 entries (01, 10, 01), then flush_req -> frame {4'h3, 30'h00000019}, flush_ack pulses once.
REQ-043 Empty flush: flush_req with count=0 -> flush_ack next cycle, frame_valid stays 0.
REQ-044 Backpressure overflow: frame_ready=0, 31 valid entries -> first frame held stable, accumulator count=15, 1 dropped, overflow=1, ovf_count=1 (macro on).
REQ-045 Simultaneous events: full accumulator, slot free, new entry same cycle -> frame count=15, dct_count=1.
REQ-046 Reset mid-PEND -> frame_valid=0 next cycle, all outputs 0; ignored codes 00/11 never change dct_count.
